bneck_layer_sequencer: RTL
==========================

Name: bneck_layer_sequencer

Overview:
- Top-level per-layer scheduler for MobileNetV3 bottleneck blocks.
- Accepts one layer descriptor per layer over a valid/ready handshake and registers the expand-stage configuration.
- Sequences the Expand → Depthwise → Project phases, enabling the expand controller and the depthwise/projection engines in turn and overlapping Depthwise with Expand when the expand controller raises its depth-start flag.
- Sits between the main controller (start/done) and the three stage controllers.

Parameters:
- LAYER_W, 5, width of layer index/count (max 32 layers).
- SIZE_W, 7, width of feature-map size fields (max 112).

Ports:
- clk  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  pulse: begin a network run (ignored unless IDLE).
- Last_Layer  in  LAYER_W  index of final layer (layer count − 1), sampled on Start.
- Cfg_Valid  in  1  descriptor valid.
- Cfg_Ready  out  1  sequencer accepts descriptor.
- Cfg_Has_Expand  in  1  0 = expansion ratio 1, expand phase skipped.
- Cfg_In_Size  in  SIZE_W  input feature-map side (1..112).
- Cfg_Final_Feature  in  3  input channel groups − 1.
- Cfg_Final_Filter  in  6  expand filter groups − 1.
- Cfg_Depth_EN  in  6  filter group at which depthwise may start.
- EX_EN  out  1  expand controller enable.
- R_Start  out  2  expand read start row/col.
- W_Start  out  2  expand write start row/col.
- R_Final_Row  out  SIZE_W  expand read last row/col.
- W_Final_Row  out  SIZE_W  expand write last row/col.
- Final_Feature  out  3  registered Cfg_Final_Feature.
- Final_Filter  out  6  registered Cfg_Final_Filter.
- Depth_EN  out  6  registered Cfg_Depth_EN.
- W_EX_Done  in  1  expand write complete.
- Depth_Start  in  1  expand controller's depth-start flag.
- DW_EN  out  1  depthwise engine enable (level).
- DW_Done  in  1  depthwise complete pulse.
- PR_EN  out  1  projection engine enable (level).
- PR_Done  in  1  projection complete pulse.
- Layer_Index  out  LAYER_W  current layer.
- Busy  out  1  high in any state except IDLE.
- All_Done  out  1  one-cycle pulse after last layer's PR_Done.
- Err  out  1  sticky protocol error.

Behaviour:
- Reset (RST=1 at edge): state=IDLE. All outputs 0, including config registers, Layer_Index and Err.
- States: IDLE, FETCH, EXPAND, DEPTH, PROJECT, NEXT.
- IDLE:
  - Start=1 → FETCH, Layer_Index=0, Last_Layer latched.
  - Start while not IDLE is ignored.
- FETCH:
  - Cfg_Ready=1 (combinational from state).
  - On Cfg_Valid&Cfg_Ready, register the descriptor and set:
    - R_Start=0, W_Start=1, R_Final_Row=Cfg_In_Size−1, W_Final_Row=Cfg_In_Size (1-pixel padded write).
    - Final_Feature, Final_Filter and Depth_EN from the descriptor.
  - Next state: EXPAND if Cfg_Has_Expand, else DEPTH with DW_EN=1 the next cycle.
- EXPAND:
  - EX_EN=1 from the cycle after acceptance.
  - Depth_Start=1 sets DW_EN=1 on the next edge; DW_EN holds until DW_Done.
  - W_EX_Done=1 → DEPTH; EX_EN=0 the next cycle. DW_EN is forced to 1 on that transition if it is not already set.
  - Depth_Start and W_EX_Done in the same cycle → DEPTH with DW_EN=1.
  - DW_Done during EXPAND → Err=1. Sequencing continues; the DW_Done is treated as consumed and DW_EN cleared.
- DEPTH:
  - Wait for DW_Done (or for the DW_Done already consumed in EXPAND).
  - DW_Done → DW_EN=0 and PR_EN=1 next cycle, state PROJECT.
- PROJECT:
  - PR_Done → PR_EN=0, state NEXT.
  - PR_Done in any other state → Err=1, ignored.
- NEXT (1 cycle):
  - If Layer_Index==Last_Layer: All_Done=1 this cycle → IDLE; Layer_Index holds.
  - Else: Layer_Index+1 → FETCH.
- Timing:
  - Minimum latency per layer without overlap, descriptor accept to PROJECT entry: 1 + expand + 1 + depthwise cycles.
  - Phase handoffs are one cycle each.
- Invariants:
  - EX_EN, DW_EN and PR_EN are registered.
  - EX_EN and PR_EN are never high together; DW_EN and PR_EN are never high together.
- Config registers hold their values until the next accepted descriptor.
- Err clears only on RST.
- RST mid-run: immediate return to IDLE, all enables 0 on that edge; in-flight descriptor discarded.

Test Plan:
- 2-layer run, both with expand:
  - Stimulus: Last_Layer=1, In_Size=56, Depth_EN=3; Depth_Start after 40 cycles of EX_EN, W_EX_Done at 100.
  - Required: DW_EN rises 1 cycle after Depth_Start while EX_EN is still high; R_Final_Row=55, W_Final_Row=56; Layer_Index 0→1; All_Done pulses once after the second PR_Done.
- No-expand layer:
  - Stimulus: Cfg_Has_Expand=0.
  - Required: EX_EN stays 0; DW_EN=1 the cycle after the handshake.
- Simultaneous events:
  - Stimulus: Depth_Start and W_EX_Done in the same cycle.
  - Required: EX_EN=0 and DW_EN=1 on the next cycle; state DEPTH; Err=0.
- Handshake back-pressure:
  - Stimulus: Cfg_Valid held low for 10 cycles in FETCH, then driven high.
  - Required: Cfg_Ready stays 1 throughout; the descriptor is captured exactly once; Cfg_Ready=0 on the next cycle.
- Protocol errors:
  - Stimulus: PR_Done during EXPAND, and DW_Done before W_EX_Done.
  - Required: Err=1 and stays set; sequencing continues to All_Done.
- Reset mid-operation:
  - Stimulus: RST=1 in PROJECT.
  - Required: PR_EN=0, Busy=0, Layer_Index=0 the next cycle; a subsequent Start runs normally.

Source files
------------

// File: rtl/bneck_layer_sequencer_if.sv
// Layer-descriptor channel between the main controller (master) and the sequencer (slave).
// Valid/ready: a descriptor transfers on any rising edge where Cfg_Valid and Cfg_Ready are both high.
interface bneck_layer_sequencer_if #(
  parameter int SIZE_W = 7
);
  logic              Cfg_Valid;
  logic              Cfg_Ready;
  logic              Cfg_Has_Expand;
  logic [SIZE_W-1:0] Cfg_In_Size;
  logic [2:0]        Cfg_Final_Feature;
  logic [5:0]        Cfg_Final_Filter;
  logic [5:0]        Cfg_Depth_EN;

  modport master (
    output Cfg_Valid, Cfg_Has_Expand, Cfg_In_Size, Cfg_Final_Feature,
           Cfg_Final_Filter, Cfg_Depth_EN,
    input  Cfg_Ready
  );

  modport slave (
    input  Cfg_Valid, Cfg_Has_Expand, Cfg_In_Size, Cfg_Final_Feature,
           Cfg_Final_Filter, Cfg_Depth_EN,
    output Cfg_Ready
  );
endinterface

// File: rtl/bneck_layer_sequencer.sv
// Per-layer scheduler for MobileNetV3 bottleneck blocks: fetches a descriptor, then runs
// Expand -> Depthwise -> Project, letting Depthwise overlap Expand once Depth_Start fires.
module bneck_layer_sequencer #(
  parameter int LAYER_W = 5,
  parameter int SIZE_W  = 7
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               Start,
  input  logic [LAYER_W-1:0] Last_Layer,
  bneck_layer_sequencer_if.slave cfg,
  output logic               EX_EN,
  output logic [1:0]         R_Start,
  output logic [1:0]         W_Start,
  output logic [SIZE_W-1:0]  R_Final_Row,
  output logic [SIZE_W-1:0]  W_Final_Row,
  output logic [2:0]         Final_Feature,
  output logic [5:0]         Final_Filter,
  output logic [5:0]         Depth_EN,
  input  logic               W_EX_Done,
  input  logic               Depth_Start,
  output logic               DW_EN,
  input  logic               DW_Done,
  output logic               PR_EN,
  input  logic               PR_Done,
  output logic [LAYER_W-1:0] Layer_Index,
  output logic               Busy,
  output logic               All_Done,
  output logic               Err,
  output logic [2:0]         Dbg_State
);

  // Debug encoding: IDLE=0 FETCH=1 EXPAND=2 DEPTH=3 PROJECT=4 NEXT=5
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXPAND  = 3'd2,
    S_DEPTH   = 3'd3,
    S_PROJECT = 3'd4,
    S_NEXT    = 3'd5
  } state_t;

  state_t             r_state;
  logic [LAYER_W-1:0] r_layer;
  logic [LAYER_W-1:0] r_last;
  logic               r_ex_en;
  logic               r_dw_en;
  logic               r_pr_en;
  logic               r_dw_consumed;
  logic               r_all_done;
  logic               r_err;
  logic [1:0]         r_r_start;
  logic [1:0]         r_w_start;
  logic [SIZE_W-1:0]  r_r_final;
  logic [SIZE_W-1:0]  r_w_final;
  logic [2:0]         r_final_feature;
  logic [5:0]         r_final_filter;
  logic [5:0]         r_depth_en;
  logic               w_accept;
  logic               w_last_layer;

  assign cfg.Cfg_Ready = (r_state == S_FETCH);
  assign w_accept      = cfg.Cfg_Valid && (r_state == S_FETCH);
  assign w_last_layer  = (r_layer == r_last);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_layer         <= '0;
      r_last          <= '0;
      r_ex_en         <= 1'b0;
      r_dw_en         <= 1'b0;
      r_pr_en         <= 1'b0;
      r_dw_consumed   <= 1'b0;
      r_all_done      <= 1'b0;
      r_err           <= 1'b0;
      r_r_start       <= '0;
      r_w_start       <= '0;
      r_r_final       <= '0;
      r_w_final       <= '0;
      r_final_feature <= '0;
      r_final_filter  <= '0;
      r_depth_en      <= '0;
    end else begin
      r_all_done <= 1'b0;
      if (PR_Done && (r_state != S_PROJECT)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_FETCH;
            r_layer <= '0;
            r_last  <= Last_Layer;
          end
        end
        S_FETCH: begin
          if (w_accept) begin
            // Read window covers the raw map; the write window is offset by the 1-pixel pad.
            r_r_start       <= 2'd0;
            r_w_start       <= 2'd1;
            r_r_final       <= cfg.Cfg_In_Size - SIZE_W'(1);
            r_w_final       <= cfg.Cfg_In_Size;
            r_final_feature <= cfg.Cfg_Final_Feature;
            r_final_filter  <= cfg.Cfg_Final_Filter;
            r_depth_en      <= cfg.Cfg_Depth_EN;
            r_dw_consumed   <= 1'b0;
            if (cfg.Cfg_Has_Expand) begin
              r_ex_en <= 1'b1;
              r_state <= S_EXPAND;
            end else begin
              r_dw_en <= 1'b1;
              r_state <= S_DEPTH;
            end
          end
        end
        S_EXPAND: begin
          if (Depth_Start && !r_dw_consumed) r_dw_en <= 1'b1;
          // An early DW_Done is flagged but still honoured so the layer can finish.
          if (DW_Done) begin
            r_err         <= 1'b1;
            r_dw_en       <= 1'b0;
            r_dw_consumed <= 1'b1;
          end
          if (W_EX_Done) begin
            r_ex_en <= 1'b0;
            r_state <= S_DEPTH;
            if (!r_dw_consumed && !DW_Done) r_dw_en <= 1'b1;
          end
        end
        S_DEPTH: begin
          if (DW_Done || r_dw_consumed) begin
            r_dw_en <= 1'b0;
            r_pr_en <= 1'b1;
            r_state <= S_PROJECT;
          end
        end
        S_PROJECT: begin
          if (PR_Done) begin
            r_pr_en    <= 1'b0;
            r_all_done <= w_last_layer;
            r_state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last_layer) begin
            r_state <= S_IDLE;
          end else begin
            r_layer <= r_layer + LAYER_W'(1);
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign EX_EN         = r_ex_en;
  assign DW_EN         = r_dw_en;
  assign PR_EN         = r_pr_en;
  assign R_Start       = r_r_start;
  assign W_Start       = r_w_start;
  assign R_Final_Row   = r_r_final;
  assign W_Final_Row   = r_w_final;
  assign Final_Feature = r_final_feature;
  assign Final_Filter  = r_final_filter;
  assign Depth_EN      = r_depth_en;
  assign Layer_Index   = r_layer;
  assign Busy          = (r_state != S_IDLE);
  assign All_Done      = r_all_done;
  assign Err           = r_err;
  assign Dbg_State     = r_state;

endmodule
